lfsr_pattern_gen: RTL and testbench

//  Parametrised Fibonacci-LFSR test pattern generator for the ATPG flow.

---
 rtl/lfsr_pattern_gen_if.sv | 29 ++
 rtl/lfsr_pattern_gen.sv | 135 +++++++++++++
 tb/tb_lfsr_pattern_gen.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pattern_gen_if.sv
// Pattern-generator bus: the controller side (start/seed/count) plus the
// valid/ready pattern stream and the run status flags.
interface lfsr_pattern_gen_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 16
);
  logic             start;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] num_patterns;
  logic             pat_ready;
  logic             pat_valid;
  logic [WIDTH-1:0] pattern;
  logic             busy;
  logic             done;
  logic             wrapped;
  logic [CNT_W-1:0] remaining;

  // Controller / pattern sink side
  modport master (
    output start, seed, num_patterns, pat_ready,
    input  pat_valid, pattern, busy, done, wrapped, remaining
  );

  // Generator side
  modport slave (
    input  start, seed, num_patterns, pat_ready,
    output pat_valid, pattern, busy, done, wrapped, remaining
  );
endinterface

// File: rtl/lfsr_pattern_gen.sv
// Fibonacci-LFSR test pattern generator. A run is started with a seed and a
// pattern count; the LFSR state is offered on a valid/ready stream and
// advances only when the sink accepts it. A sticky flag records whether the
// sequence came back round to the run seed.
module lfsr_pattern_gen #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = 5'b10100,
  parameter int               CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  lfsr_pattern_gen_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The all-zero state is a fixed point of an XOR LFSR, so it is never loaded.
  localparam logic [WIDTH-1:0] LFSR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_safe;
  logic             accept_start;
  logic             xfer;
  logic             last_xfer;

  // One Fibonacci shift: feedback is the parity of the tapped bits, shifted in at bit 0.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur);
    logic fb;
    fb = ^(cur & TAPS);
    return {cur[WIDTH-2:0], fb};
  endfunction

  // Replace a lockup (all-zero) seed with the canonical non-zero start state.
  function automatic logic [WIDTH-1:0] guard_seed(input logic [WIDTH-1:0] s);
    return (s == '0) ? LFSR_ONE : s;
  endfunction

  // Decode the events that drive the FSM this cycle.
  always_comb begin
    lfsr_next    = lfsr_step(lfsr);
    seed_safe    = guard_seed(bus.seed);
    accept_start = 1'b0;
    xfer         = 1'b0;
    last_xfer    = 1'b0;
    if (state == IDLE && bus.start) begin
      accept_start = 1'b1;
    end
    if (state == RUN && bus.pat_valid && bus.pat_ready) begin
      xfer      = 1'b1;
      last_xfer = (bus.remaining == CNT_ONE);
    end
  end

  // Run seed is pure data: captured on an accepted start, no reset needed.
  always_ff @(posedge clk) begin
    if (accept_start) begin
      seed_q <= seed_safe;
    end
  end

  // Run control FSM with registered status outputs, LFSR and pattern counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= LFSR_ONE;
      bus.pat_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.wrapped   <= 1'b0;
      bus.remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (accept_start) begin
            lfsr          <= seed_safe;
            bus.remaining <= bus.num_patterns;
            bus.wrapped   <= 1'b0;
            bus.busy      <= 1'b1;
            if (bus.num_patterns != '0) begin
              state         <= RUN;
              bus.pat_valid <= 1'b1;
            end else begin
              // Empty run: straight to the end-of-run pulse, nothing offered.
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end
        end

        RUN: begin
          if (xfer) begin
            lfsr <= lfsr_next;
            if (bus.remaining != '0) begin
              bus.remaining <= bus.remaining - CNT_ONE;
            end
            if (lfsr_next == seed_q) begin
              bus.wrapped <= 1'b1;
            end
            if (last_xfer) begin
              state         <= DONE;
              bus.pat_valid <= 1'b0;
              bus.done      <= 1'b1;
            end
          end
        end

        DONE: begin
          // Single-cycle end-of-run state; a start seen here is dropped.
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          bus.pat_valid <= 1'b0;
          bus.busy      <= 1'b0;
          bus.done      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pattern = lfsr;

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Bench for lfsr_pattern_gen: reset, a cycle-by-cycle vector table, directed
// corner-case runs and randomized runs against a sequence model.
module tb_lfsr_pattern_gen;

  localparam int W  = 5;
  localparam int CW = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [W-1:0] obs [0:63];

  lfsr_pattern_gen_if #(.WIDTH(W), .CNT_W(CW)) bus_if ();

  lfsr_pattern_gen #(.WIDTH(W), .TAPS(5'b10100), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         start;
    logic [W-1:0] seed;
    logic [CW-1:0] num;
    logic         ready;
    logic         exp_valid;
    logic [W-1:0] exp_pat;
    logic         exp_done;
    logic         exp_busy;
    logic [CW-1:0] exp_rem;
  } vec_t;

  vec_t vec [0:7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Next pattern from the polynomial x^5+x^3+1: double modulo 32, add the
  // parity of bits 4 and 2.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] s);
    int v;
    v = (int'(s) * 2) % 32 + ($countones(s & 5'b10100) % 2);
    return W'(v);
  endfunction

  // One full run: mode 0 = always ready, 1 = random ready with stray starts,
  // 2 = ready on every third cycle.
  task automatic run(input logic [W-1:0] s, input int num, input int mode);
    logic [W-1:0] seq [0:63];
    int   k;
    int   cyc;
    logic r;
    logic exp_w;
    seq[0] = (s == '0) ? W'(1) : s;
    for (int i = 1; i < 64; i++) seq[i] = model_next(seq[i-1]);

    bus_if.seed         = s;
    bus_if.num_patterns = CW'(num);
    bus_if.pat_ready    = 1'b0;
    bus_if.start        = 1'b1;
    step();
    bus_if.start = 1'b0;

    if (num == 0) begin
      check("empty_valid", bus_if.pat_valid, 0);
      check("empty_done", bus_if.done, 1);
      check("empty_busy", bus_if.busy, 1);
      check("empty_rem", bus_if.remaining, 0);
      step();
      check("empty_done_low", bus_if.done, 0);
      check("empty_busy_low", bus_if.busy, 0);
      return;
    end

    k = 0;
    cyc = 0;
    exp_w = 1'b0;
    while (k < num && cyc < 400) begin
      check("run_valid", bus_if.pat_valid, 1);
      check("run_pattern", bus_if.pattern, seq[k]);
      check("run_rem", bus_if.remaining, num - k);
      check("run_wrapped", bus_if.wrapped, exp_w);
      check("run_done", bus_if.done, 0);
      check("run_busy", bus_if.busy, 1);
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (cyc % 3 == 0);
      endcase
      if (mode == 1) begin
        bus_if.start        = ($urandom_range(0, 3) == 0);
        bus_if.seed         = W'($urandom);
        bus_if.num_patterns = CW'($urandom_range(0, 50));
      end
      bus_if.pat_ready = r;
      if (r) obs[k] = bus_if.pattern;
      step();
      if (r) begin
        k++;
        if (seq[k] == seq[0]) exp_w = 1'b1;
      end
      cyc++;
    end
    bus_if.start     = 1'b0;
    bus_if.pat_ready = 1'b0;
    check("run_transfers_within_budget", k, num);

    check("end_valid", bus_if.pat_valid, 0);
    check("end_done", bus_if.done, 1);
    check("end_busy", bus_if.busy, 1);
    check("end_rem", bus_if.remaining, 0);
    check("end_wrapped", bus_if.wrapped, exp_w);
    check("end_pattern", bus_if.pattern, seq[num]);
    step();
    check("idle_done", bus_if.done, 0);
    check("idle_busy", bus_if.busy, 0);
    check("idle_valid", bus_if.pat_valid, 0);
  endtask

  initial begin
    int distinct;
    logic dup;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.start        = 1'b0;
    bus_if.seed         = '0;
    bus_if.num_patterns = '0;
    bus_if.pat_ready    = 1'b0;

    // Reset state
    step();
    step();
    check("rst_valid", bus_if.pat_valid, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_rem", bus_if.remaining, 0);
    check("rst_pattern", bus_if.pattern, 5'b00001);
    check("rst_wrapped", bus_if.wrapped, 0);
    rst = 1'b0;
    step();

    // Cycle-by-cycle six-pattern run; start while busy (RUN and DONE) ignored.
    vec[0] = '{1'b1, 5'b00001, 16'd6, 1'b1, 1'b1, 5'b00001, 1'b0, 1'b1, 16'd6};
    vec[1] = '{1'b0, 5'b00001, 16'd6, 1'b1, 1'b1, 5'b00010, 1'b0, 1'b1, 16'd5};
    vec[2] = '{1'b0, 5'b00001, 16'd6, 1'b1, 1'b1, 5'b00100, 1'b0, 1'b1, 16'd4};
    vec[3] = '{1'b1, 5'b10101, 16'd2, 1'b1, 1'b1, 5'b01001, 1'b0, 1'b1, 16'd3};
    vec[4] = '{1'b0, 5'b00001, 16'd6, 1'b1, 1'b1, 5'b10010, 1'b0, 1'b1, 16'd2};
    vec[5] = '{1'b0, 5'b00001, 16'd6, 1'b1, 1'b1, 5'b00101, 1'b0, 1'b1, 16'd1};
    vec[6] = '{1'b0, 5'b00001, 16'd6, 1'b1, 1'b0, 5'b01011, 1'b1, 1'b1, 16'd0};
    vec[7] = '{1'b1, 5'b00011, 16'd5, 1'b0, 1'b0, 5'b01011, 1'b0, 1'b0, 16'd0};
    for (int i = 0; i < 8; i++) begin
      bus_if.start        = vec[i].start;
      bus_if.seed         = vec[i].seed;
      bus_if.num_patterns = vec[i].num;
      bus_if.pat_ready    = vec[i].ready;
      step();
      check($sformatf("vec%0d_valid", i), bus_if.pat_valid, vec[i].exp_valid);
      check($sformatf("vec%0d_pattern", i), bus_if.pattern, vec[i].exp_pat);
      check($sformatf("vec%0d_done", i), bus_if.done, vec[i].exp_done);
      check($sformatf("vec%0d_busy", i), bus_if.busy, vec[i].exp_busy);
      check($sformatf("vec%0d_rem", i), bus_if.remaining, vec[i].exp_rem);
    end
    bus_if.start     = 1'b0;
    bus_if.pat_ready = 1'b0;
    step();
    check("after_done_start_valid", bus_if.pat_valid, 0);
    check("after_done_start_busy", bus_if.busy, 0);

    // Full period: 31 distinct non-zero patterns, then the seed again.
    run(5'b00001, 32, 0);
    distinct = 0;
    for (int i = 0; i < 31; i++) begin
      dup = (obs[i] == '0);
      for (int j = 0; j < i; j++) if (obs[j] == obs[i]) dup = 1'b1;
      if (!dup) distinct++;
    end
    check("period_distinct_nonzero", distinct, 31);
    check("period_32nd_is_seed", obs[31], 5'b00001);

    // Backpressure, lockup seed, empty run
    run(5'b10101, 4, 2);
    run(5'b00000, 3, 0);
    run(5'b01110, 0, 0);

    // Reset mid-run at remaining==3 aborts without a done pulse.
    bus_if.seed         = 5'b00001;
    bus_if.num_patterns = 16'd10;
    bus_if.start        = 1'b1;
    step();
    bus_if.start     = 1'b0;
    bus_if.pat_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    bus_if.pat_ready = 1'b0;
    check("midrun_rem_before_rst", bus_if.remaining, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrun_rst_valid", bus_if.pat_valid, 0);
    check("midrun_rst_busy", bus_if.busy, 0);
    check("midrun_rst_done", bus_if.done, 0);
    check("midrun_rst_rem", bus_if.remaining, 0);
    check("midrun_rst_pattern", bus_if.pattern, 5'b00001);
    step();
    check("midrun_no_done_pulse", bus_if.done, 0);
    run(5'b01100, 5, 1);

    // Randomized runs
    for (int t = 0; t < 12; t++) begin
      run(W'($urandom), $urandom_range(0, 40), $urandom_range(0, 2));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
